sized_data_memory: RTL and testbench
====================================

# sized_data_memory

- Word-addressed data memory for the single-cycle/multi-cycle CPU datapath.
- Successor to the fixed-word data memory: adds RISC-V sub-word loads/stores (byte/half, signed/unsigned), byte-lane writes, fault reporting, a configurable access latency behind a valid/ready request handshake, and a post-reset clear sweep.
- Sits between the CPU load/store unit and the memory array; the LSU issues one request and waits for `resp_valid`.

## Interface
- `MEM_DEPTH`, 16384: number of 32-bit words; power of two, ≥4. `ADDR_W = $clog2(MEM_DEPTH)`.
- `LATENCY`, 2: cycles from request acceptance to response; integer ≥1.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 size/sign code.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  load result, extended to 32 bits; 0 for stores and on error.
- `resp_error`  out  1  request faulted, valid with `resp_valid`.
- `init_done`  out  1  clear sweep finished.

## Operation
- FSM states: INIT, IDLE, WAIT, RESP.
- **INIT**
  - While `reset`=1: state INIT, clear index=0, all outputs 0.
  - After release: writes 0 to one word per cycle, index 0..MEM_DEPTH-1, then goes to IDLE.
- **IDLE**
  - `req_ready`=1 only here.
  - Accept = `req_valid & req_ready`; captures write, funct3, addr and wdata.
  - Next state is WAIT if LATENCY>1, otherwise RESP.
- **WAIT**
  - Counts LATENCY-1 cycles.
  - Inputs are ignored.
- **Memory access**
  - Performed on the edge entering RESP.
  - Read data is registered; the write is committed on the same edge.
- **RESP**
  - `resp_valid`=1 for exactly one cycle, then IDLE.
  - No back-pressure on the response.
- **Word index and lanes**
  - Word index = `addr[ADDR_W+1:2]`.
  - Little-endian lanes: byte lane = `addr[1:0]`, half lane = `addr[1]`.
- **Loads**
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: full word.
  - 100 LBU, 101 LHU: zero-extended.
- **Stores**
  - 000 SB, 001 SH, 010 SW.
  - Only the addressed lanes are modified; other bytes of the word are unchanged.
- **Errors**: `resp_error`=1, `resp_rdata`=0, memory unchanged. Causes:
  - Illegal funct3: load 011/110/111; store with any code other than 000/001/010.
  - Misalignment: half with `addr[0]`=1; word with `addr[1:0]`≠0.
  - Out of range: `addr[31:ADDR_W+2]`≠0.
- **Outputs between responses**: `resp_rdata`/`resp_error` hold 0 when `resp_valid`=0.

## Timing
- **Reset values**: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `init_done`=0.
- **Release timing**: first cycle after reset release is cycle 0. `init_done` and `req_ready` first go high in cycle MEM_DEPTH.
- **Response latency**: accepted in cycle t → `resp_valid` in cycle t+LATENCY.
- **Throughput**: next accept possible in cycle t+LATENCY+1, so at most one request per LATENCY+1 cycles.
- **Reset mid-operation**
  - Outstanding request is dropped; no response is produced.
  - An uncommitted write is discarded.
  - The sweep restarts from index 0.
- **Visibility**: a load issued after a store's RESP cycle sees the store data.
- **Ignored requests**: `req_valid` while `req_ready`=0 is ignored and not queued; the requester holds it.

## Test plan
- **Reset/init, MEM_DEPTH=16**
  - Stimulus: pulse reset 2 cycles.
  - Required: `req_ready`=0 for cycles 0..15 and 1 at cycle 16; LW of every word returns 0.
- **Word round trip, LATENCY=3**
  - Stimulus: SW 0xDEADBEEF @0x40 accepted at t, then LW @0x40.
  - Required: `resp_valid` only at t+3 with error 0; load returns 0xDEADBEEF.
- **Sub-word stores and loads**
  - Stimulus: starting from word 0x11223344 @0x80, SB 0xAA @0x81, then SH 0xBEEF @0x82.
  - Required: LW → 0xBEEFAA44; LB @0x81 → 0xFFFFFFAA; LBU @0x81 → 0x000000AA; LH @0x82 → 0xFFFFBEEF; LHU → 0x0000BEEF.
- **Faults**
  - Stimulus: LW @0x42; SH @0x81; load funct3=011; LW @ (MEM_DEPTH*4).
  - Required: each gives `resp_error`=1, rdata 0; a subsequent LW @0x40 is unchanged.
- **Handshake**
  - Stimulus: hold `req_valid`=1 continuously.
  - Required: accepts spaced exactly LATENCY+1 cycles; `req_ready`=0 in WAIT/RESP; no duplicate responses.
- **Reset mid-WAIT**
  - Stimulus: SW 0x5 @0x10, assert reset in WAIT.
  - Required: no `resp_valid`; after the sweep, LW @0x10 → 0.

Source files
------------

// File: rtl/sized_data_memory.sv
// rtl/sized_data_memory.sv - word-addressed data memory with RISC-V sub-word access,
// fault reporting, fixed access latency and a post-reset clear sweep.
module sized_data_memory #(
  parameter int MEM_DEPTH = 16384,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        init_done
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;
  state_t state, next_state;

  logic [ADDR_W-1:0] clr_idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic              cap_write;
  logic [2:0]        cap_funct3;
  logic [31:0]       cap_addr;
  logic [31:0]       cap_wdata;
  logic [31:0]       mem [MEM_DEPTH];

  logic              accept;
  logic              go_resp;
  logic              acc_write;
  logic [2:0]        acc_funct3;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val;
  logic [3:0]        wmask;
  logic [31:0]       wlanes;
  logic              illegal, misalign, out_of_range, err;

  // With LATENCY=1 the access happens on the accepting edge, so use live inputs in IDLE.
  assign acc_write  = (state == IDLE) ? req_write  : cap_write;
  assign acc_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;
  assign acc_addr   = (state == IDLE) ? req_addr   : cap_addr;
  assign acc_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;
  assign acc_idx    = acc_addr[ADDR_W+1:2];
  assign rd_word    = mem[acc_idx];
  assign byte_sel   = rd_word[{acc_addr[1:0], 3'b000} +: 8];
  assign half_sel   = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    illegal      = acc_write ? (acc_funct3 > 3'd2)
                             : (acc_funct3 == 3'b011 || acc_funct3[2:1] == 2'b11);
    misalign     = (acc_funct3[1:0] == 2'b01 && acc_addr[0]) ||
                   (acc_funct3[1:0] == 2'b10 && acc_addr[1:0] != 2'b00);
    out_of_range = (acc_addr >> (ADDR_W + 2)) != 32'd0;
    err          = illegal || misalign || out_of_range;

    case (acc_funct3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'b0, byte_sel};
      3'b101:  load_val = {16'b0, half_sel};
      default: load_val = 32'b0;
    endcase

    case (acc_funct3[1:0])
      2'b00: begin
        wmask  = 4'b0001 << acc_addr[1:0];
        wlanes = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wmask  = acc_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{acc_wdata[15:0]}};
      end
      default: begin
        wmask  = 4'b1111;
        wlanes = acc_wdata;
      end
    endcase
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    init_done  = (state != INIT);
    accept     = 1'b0;
    case (state)
      INIT: if (clr_idx == LAST_IDX) next_state = IDLE;
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) next_state = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: if (wait_cnt == WAIT_LAST) next_state = RESP;
      RESP: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = INIT;
    endcase
    go_resp = (next_state == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      clr_idx    <= '0;
      wait_cnt   <= '0;
      cap_write  <= 1'b0;
      cap_funct3 <= 3'b0;
      cap_addr   <= 32'b0;
      cap_wdata  <= 32'b0;
      resp_rdata <= 32'b0;
      resp_error <= 1'b0;
    end else begin
      state <= next_state;
      if (state == INIT) clr_idx <= clr_idx + ADDR_W'(1);
      if (accept) begin
        cap_write  <= req_write;
        cap_funct3 <= req_funct3;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
        wait_cnt   <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      resp_rdata <= (go_resp && !err && !acc_write) ? load_val : 32'b0;
      resp_error <= go_resp && err;
    end
  end

  // Array has no reset; contents are cleared by the sweep instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        mem[clr_idx] <= 32'b0;
      end else if (go_resp && acc_write && !err) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mem[acc_idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// tb/tb_sized_data_memory.sv - randomized self-checking bench for sized_data_memory
// against a byte-array reference model.
module tb_sized_data_memory;
  localparam int MEM_DEPTH = 64;
  localparam int LATENCY   = 3;
  localparam int NBYTES    = MEM_DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        init_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl_mem [NBYTES];

  sized_data_memory #(.MEM_DEPTH(MEM_DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat little-endian byte array; sizes and legality by table.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er);
    int n;
    logic legal;
    logic [31:0] v;
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
              : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    er = !legal || (a >= 32'(NBYTES)) || (a % n != 0);
    rd = 32'b0;
    if (!er && w) begin
      for (int k = 0; k < n; k++) mdl_mem[a + k] = 8'(d >> (8 * k));
    end else if (!er) begin
      v = 32'b0;
      for (int k = 0; k < n; k++) v = v | (32'(mdl_mem[a + k]) << (8 * k));
      if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endtask

  task automatic reset_sweep();
    int ready_at;
    logic saw_resp;
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_error", 32'(resp_error), 0);
    chk("rst_init_done", 32'(init_done), 0);
    reset = 1'b0;
    ready_at = -1;
    saw_resp = 1'b0;
    for (int k = 0; k < MEM_DEPTH + 8; k++) begin
      if (resp_valid) saw_resp = 1'b1;
      if (req_ready) begin
        ready_at = k;
        break;
      end
      @(negedge clk);
    end
    chk("init_ready_cycle", 32'(ready_at), 32'(MEM_DEPTH));
    chk("init_done_at_ready", 32'(init_done), 1);
    chk("no_resp_in_sweep", 32'(saw_resp), 0);
    for (int i = 0; i < NBYTES; i++) mdl_mem[i] = 8'h00;
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd_out);
    int n;
    logic [31:0] er_d;
    logic er_e;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    rd_out = 32'b0;
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int i = 1; i < LATENCY; i++) begin
      chk("wait_ready_resp", {30'b0, req_ready, resp_valid}, 0);
      @(negedge clk);
    end
    model(w, f3, a, d, er_d, er_e);
    chk("resp_valid", 32'(resp_valid), 1);
    chk("resp_rdata", resp_rdata, er_d);
    chk("resp_error", 32'(resp_error), 32'(er_e));
    rd_out = resp_rdata;
    @(negedge clk);
    chk("resp_single", {29'b0, resp_valid, resp_error, |resp_rdata}, 0);
  endtask

  task automatic handshake();
    int acc[$];
    int rsp[$];
    logic overlap;
    overlap = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 0;
    for (int n = 0; n < 60; n++) begin
      if (req_ready) acc.push_back(n);
      if (resp_valid) rsp.push_back(n);
      if (req_ready && resp_valid) overlap = 1'b1;
      if (rsp.size() >= 4) break;
      @(negedge clk);
      if (acc.size() >= 4) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    chk("hs_accepts", 32'(acc.size()), 4);
    chk("hs_responses", 32'(rsp.size()), 4);
    chk("hs_overlap", 32'(overlap), 0);
    if (acc.size() == 4 && rsp.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("hs_spacing", 32'(acc[i] - acc[i-1]), 32'(LATENCY + 1));
      for (int i = 0; i < 4; i++) chk("hs_latency", 32'(rsp[i] - acc[i]), 32'(LATENCY));
    end
    overlap = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) overlap = 1'b1;
    end
    chk("hs_no_extra_resp", 32'(overlap), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic w;
    logic [2:0] f3;
    logic [31:0] a;
    int n;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'b0; req_addr = 32'b0; req_wdata = 32'b0;

    reset_sweep();
    for (int i = 0; i < MEM_DEPTH; i++) do_req(1'b0, 3'd2, 32'(4 * i), 32'b0, r);

    do_req(1'b1, 3'd2, 32'h40, 32'hDEADBEEF, r);
    do_req(1'b0, 3'd2, 32'h40, 32'b0, r);
    chk("lw_roundtrip", r, 32'hDEADBEEF);

    do_req(1'b1, 3'd2, 32'h80, 32'h11223344, r);
    do_req(1'b1, 3'd0, 32'h81, 32'h000000AA, r);
    do_req(1'b1, 3'd1, 32'h82, 32'h0000BEEF, r);
    do_req(1'b0, 3'd2, 32'h80, 0, r); chk("sub_lw", r, 32'hBEEFAA44);
    do_req(1'b0, 3'd0, 32'h81, 0, r); chk("sub_lb", r, 32'hFFFFFFAA);
    do_req(1'b0, 3'd4, 32'h81, 0, r); chk("sub_lbu", r, 32'h000000AA);
    do_req(1'b0, 3'd1, 32'h82, 0, r); chk("sub_lh", r, 32'hFFFFBEEF);
    do_req(1'b0, 3'd5, 32'h82, 0, r); chk("sub_lhu", r, 32'h0000BEEF);

    do_req(1'b0, 3'd2, 32'h42, 0, r);
    do_req(1'b1, 3'd1, 32'h81, 32'h1234, r);
    do_req(1'b0, 3'd3, 32'h40, 0, r);
    do_req(1'b0, 3'd2, 32'(NBYTES), 0, r);
    do_req(1'b1, 3'd2, 32'(NBYTES), 32'h0BAD0BAD, r);
    do_req(1'b0, 3'd2, 32'h40, 0, r); chk("fault_mem_unchanged", r, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h80, 0, r); chk("fault_sh_unchanged", r, 32'hBEEFAA44);

    handshake();

    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom);
      f3 = 3'($urandom);
      n  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      a  = $urandom_range(0, NBYTES - 1);
      if ($urandom_range(0, 9) < 7) a = a & ~32'(n - 1);
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(8, 31));
      do_req(w, f3, a, $urandom, r);
    end

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h10; req_wdata = 32'h5;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("midwait_in_wait", {30'b0, req_ready, resp_valid}, 0);
    reset_sweep();
    do_req(1'b0, 3'd2, 32'h10, 0, r);
    chk("midwait_store_dropped", r, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
